// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side client for one port of a 1-cycle-latency block RAM. On start it
//   walks a contiguous (modulo DEPTH) address range. It issues one read per
//   cycle while the downstream buffer has room. Returned words are emitted
//   as a valid/ready stream through a 2-entry buffer, which absorbs the RAM's
//   fixed read latency under backpressure.
//
//   Optional feature macro: BRAM_RD_STRIDE_EN
//     When defined, an extra input `stride` sets the address increment
//     (modulo DEPTH). Otherwise the increment is fixed at 1.
//
//   Ports
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   begin a transfer (sampled only in IDLE)
//     base_addr  in   [AW-1:0] first address, sampled with start
//     len        in   [AW:0]   word count 0..DEPTH, sampled with start
//     stride     in   [AW-1:0] address increment (BRAM_RD_STRIDE_EN only)
//     busy       out  transfer in progress
//     done       out  one-cycle completion pulse
//     mem_en     out  RAM port enable
//     mem_we     out  constant 0
//     mem_addr   out  [AW-1:0] RAM port address
//     mem_din    out  [DW-1:0] constant 0
//     mem_dout   in   [DW-1:0] RAM read data, valid the cycle after mem_en
//     m_valid    out  stream valid
//     m_ready    in   stream ready
//     m_data     out  [DW-1:0] stream data (signed)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start
//   RUN    | issuing reads while buffer + in-flight leaves room
//   DRAIN  | all reads issued; waiting for in-flight word and buffer
//   DONE   | done pulse, back to IDLE next cycle
module bram_stream_reader #(
   parameter int DW    = 16,
   parameter int DEPTH = 1024,
   parameter int AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          len,
`ifdef BRAM_RD_STRIDE_EN
   input  logic [AW-1:0]        stride,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_din,
   input  logic signed [DW-1:0] mem_dout,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [DW-1:0] m_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t                state;
   logic [AW-1:0]         addr_q;
   logic [AW-1:0]         step_q;
   logic [AW:0]           remain_q;
   logic                  inflight_q;
   logic [1:0]            count_q;
   logic signed [DW-1:0]  buf0_q;
   logic signed [DW-1:0]  buf1_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  pop;
   logic                  issue;
   logic [2:0]            occ_after;
   logic [AW:0]           addr_sum;
   logic [AW-1:0]         addr_next;
   logic [AW-1:0]         step_in;

   assign pop = (count_q != 2'd0) && m_ready;

   // Buffered + in-flight words remaining after this cycle's pop; a read may
   // be issued only while that leaves a free buffer slot for its return.
   always_comb begin
      occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue     = (state == S_RUN) && (occ_after < 3'd2);
   end

   // Both operands are below DEPTH, so a single conditional subtract wraps
   // correctly even for non-power-of-two depths.
   always_comb begin
      addr_sum  = {1'b0, addr_q} + {1'b0, step_q};
      addr_next = (addr_sum >= DEPTH_W) ? AW'(addr_sum - DEPTH_W) : AW'(addr_sum);
   end

`ifdef BRAM_RD_STRIDE_EN
   logic [AW:0] stride_w;
   always_comb begin
      stride_w = {1'b0, stride};
      step_in  = (stride_w >= DEPTH_W) ? AW'(stride_w - DEPTH_W) : stride;
   end
`else
   assign step_in = AW'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         step_q     <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;

         // Return buffer: the in-flight word lands the cycle after issue.
         if (inflight_q && !pop) begin
            if (count_q == 2'd0) buf0_q <= mem_dout;
            else                 buf1_q <= mem_dout;
            count_q <= count_q + 2'd1;
         end else if (!inflight_q && pop) begin
            buf0_q  <= buf1_q;
            count_q <= count_q - 2'd1;
         end else if (inflight_q && pop) begin
            if (count_q == 2'd1) begin
               buf0_q <= mem_dout;
            end else begin
               buf0_q <= buf1_q;
               buf1_q <= mem_dout;
            end
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= base_addr;
                  step_q   <= step_in;
                  remain_q <= len;
                  busy_q   <= 1'b1;
                  if (len == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  remain_q <= remain_q - (AW+1)'(1);
                  // Keep the address on the last read so mem_addr holds.
                  if (remain_q == (AW+1)'(1)) state  <= S_DRAIN;
                  else                        addr_q <= addr_next;
               end
            end
            S_DRAIN: begin
               if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_en   = issue;
   assign mem_we   = 1'b0;
   assign mem_addr = addr_q;
   assign mem_din  = '0;
   assign m_valid  = (count_q != 2'd0);
   assign m_data   = buf0_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

   localparam int DW    = 16;
   localparam int DEPTH = 1000;
   localparam int AW    = 10;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [AW-1:0]        base_addr;
   logic [AW:0]          len;
`ifdef BRAM_RD_STRIDE_EN
   logic [AW-1:0]        stride;
`endif
   logic                 busy;
   logic                 done;
   logic                 mem_en;
   logic                 mem_we;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_din;
   logic signed [DW-1:0] mem_dout;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_data;

   logic signed [DW-1:0] mem [DEPTH];

   int n_tests = 0;
   int n_fail  = 0;

   bram_stream_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
`ifdef BRAM_RD_STRIDE_EN
      .stride    (stride),
`endif
      .busy      (busy),
      .done      (done),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 1-cycle-latency RAM model
   always @(posedge clk) begin
      if (mem_en && (int'(mem_addr) < DEPTH)) mem_dout <= mem[mem_addr];
   end

   // Runs one transfer and checks it against a transaction-level model:
   // expected address k is (base + k*stride) mod DEPTH, expected beat k is
   // the RAM word at that address, and a read is allowed exactly when the
   // words issued-but-not-yet-consumed, minus this cycle's pop, is below 2.
   task automatic run_xfer(input int base, input int ln, input int strd,
                           input int rmode, input bit chk_timing,
                           input bit poke_start, input string name);
      int                   exp_addr[$];
      logic signed [DW-1:0] exp_data[$];
      int                   issued, popped, c, done_c, first_c, last_c, a;
      bit                   pop_now, exp_en, prev_stall;
      logic [DW-1:0]        prev_data;
      issued = 0; popped = 0; done_c = -1; first_c = -1; last_c = -1;
      prev_stall = 1'b0; prev_data = '0;
      for (int k = 0; k < ln; k++) begin
         a = (base + k * strd) % DEPTH;
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
      end
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = AW'(base);
      len       = (AW+1)'(ln);
`ifdef BRAM_RD_STRIDE_EN
      stride    = AW'(strd);
`endif
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = AW'($urandom_range(0, DEPTH-1));
      len       = (AW+1)'($urandom_range(0, DEPTH));
`ifdef BRAM_RD_STRIDE_EN
      stride    = AW'($urandom_range(0, DEPTH-1));
`endif
      c = 1;
      forever begin
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((c % 3) == 1);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke_start) begin
            if (c == 2) begin
               start     = 1'b1;
               base_addr = AW'($urandom_range(0, DEPTH-1));
               len       = (AW+1)'(7);
            end else begin
               start     = 1'b0;
            end
         end
         @(negedge clk);
         pop_now = m_valid && m_ready;
         exp_en  = (issued < ln) && ((issued - popped - int'(pop_now)) < 2);
         n_tests++;
         if (mem_en !== exp_en) begin
            n_fail++;
            $display("FAIL %s mem_en cycle %0d: got %b want %b", name, c, mem_en, exp_en);
         end
         if (mem_en === 1'b1 && issued < ln) begin
            n_tests++;
            if (mem_addr !== AW'(exp_addr[issued])) begin
               n_fail++;
               $display("FAIL %s mem_addr read %0d: got %0d want %0d", name, issued, mem_addr, exp_addr[issued]);
            end
            issued++;
         end
         if (prev_stall) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               n_fail++;
               $display("FAIL %s stall stability cycle %0d: got v=%b d=%0d want v=1 d=%0d", name, c, m_valid, m_data, prev_data);
            end
         end
         if (pop_now) begin
            n_tests++;
            if (popped >= ln) begin
               n_fail++;
               $display("FAIL %s extra beat: got beat %0d want %0d beats", name, popped + 1, ln);
            end else if (m_data !== exp_data[popped]) begin
               n_fail++;
               $display("FAIL %s beat %0d data: got %0d want %0d", name, popped, m_data, exp_data[popped]);
            end
            if (popped == 0) first_c = c;
            last_c = c;
            popped++;
         end
         n_tests++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy cycle %0d: got %b want 1", name, c, busy);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         if (done === 1'b1) begin
            done_c = c;
            break;
         end
         if (c >= 400) begin
            n_fail++;
            $display("FAIL %s timeout: got no done want done within 400 cycles", name);
            break;
         end
         @(posedge clk); #1;
         c++;
      end
      n_tests++;
      if (popped != ln || issued != ln) begin
         n_fail++;
         $display("FAIL %s counts: got %0d beats %0d reads want %0d", name, popped, issued, ln);
      end
      if (chk_timing) begin
         n_tests++;
         if (done_c != ((ln == 0) ? 1 : ln + 3)) begin
            n_fail++;
            $display("FAIL %s done cycle: got %0d want %0d", name, done_c, (ln == 0) ? 1 : ln + 3);
         end
         if (ln > 0) begin
            n_tests++;
            if (first_c != 3 || last_c != ln + 2) begin
               n_fail++;
               $display("FAIL %s beat cycles: got %0d..%0d want 3..%0d", name, first_c, last_c, ln + 2);
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after done: got busy=%b done=%b want 0 0", name, busy, done);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_tests++;
      if ({busy, done, mem_en, mem_we, m_valid} !== 5'b0 || mem_addr !== '0 ||
          mem_din !== '0 || m_data !== '0) begin
         n_fail++;
         $display("FAIL %s outputs: got busy=%b done=%b en=%b we=%b addr=%0d din=%0d v=%b d=%0d want all 0",
                  name, busy, done, mem_en, mem_we, mem_addr, mem_din, m_valid, m_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
`ifdef BRAM_RD_STRIDE_EN
      stride = '0;
`endif
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset_idle");
   endtask

   task automatic test_full_rate();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      run_xfer(10, 4, 1, 0, 1'b1, 1'b0, "full_rate");
   endtask

   task automatic test_backpressure();
      run_xfer(int'($urandom_range(0, DEPTH-1)), 6, 1, 1, 1'b0, 1'b0, "backpressure");
   endtask

   task automatic test_wrap();
      run_xfer(998, 4, 1, 0, 1'b1, 1'b0, "wrap");
   endtask

   task automatic test_zero_len();
      run_xfer(int'($urandom_range(0, DEPTH-1)), 0, 1, 0, 1'b1, 1'b0, "zero_len");
   endtask

   task automatic test_ignored_start();
      run_xfer(100, 5, 1, 0, 1'b1, 1'b1, "ignored_start");
   endtask

   task automatic test_async_reset();
      int beats;
      beats = 0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(500); len = (AW+1)'(8); m_ready = 1'b1;
`ifdef BRAM_RD_STRIDE_EN
      stride = AW'(1);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (m_valid === 1'b1) beats++;
         if (beats == 2) break;
         @(posedge clk); #1;
      end
      n_tests++;
      if (beats != 2) begin
         n_fail++;
         $display("FAIL async_reset setup: got %0d beats want 2", beats);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      for (int c = 0; c < 3; c++) @(negedge clk);
      check_all_zero("async_reset_hold");
      rst_n = 1'b1;
      run_xfer(int'($urandom_range(0, DEPTH-1)), 3, 1, 0, 1'b1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int strd;
      for (int t = 0; t < 8; t++) begin
         strd = 1;
`ifdef BRAM_RD_STRIDE_EN
         strd = int'($urandom_range(0, DEPTH-1));
`endif
         run_xfer(int'($urandom_range(DEPTH-20, DEPTH-1)) - int'($urandom_range(0, 1)) * 500,
                  int'($urandom_range(1, 20)), strd, 2, 1'b0, 1'b0, "random");
      end
   endtask

`ifdef BRAM_RD_STRIDE_EN
   task automatic test_stride();
      run_xfer(0, 3, 28, 0, 1'b1, 1'b0, "stride");
      run_xfer(int'($urandom_range(0, DEPTH-1)), 4, 0, 2, 1'b0, 1'b0, "stride_zero");
   endtask
`endif

   initial begin
      test_reset();
      test_full_rate();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_ignored_start();
      test_async_reset();
      test_random();
`ifdef BRAM_RD_STRIDE_EN
      test_stride();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side client for a single port of the team's 1-cycle-latency block RAM. On `start` it walks a contiguous address range, issues one read per cycle when downstream has room, and emits the returned words as a valid/ready stream. A 2-entry output buffer absorbs the RAM's fixed read latency under backpressure. It sits between feature-map/weight BRAMs and the conv/pool datapaths.

## Interface
- `DW`, 16: word width; signed data.
- `DEPTH`, 1024: RAM depth in words.
- `AW`, `(DEPTH<=1) ? 1 : $clog2(DEPTH)`: address width.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `base_addr`  in  AW  first address; sampled with `start`.
- `len`  in  AW+1  number of words, 0..DEPTH; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  RAM port enable.
- `mem_we`  out  1  constant 0.
- `mem_addr`  out  AW  RAM port address.
- `mem_din`  out  DW  constant 0.
- `mem_dout`  in  DW  RAM read data, valid the cycle after `mem_en`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream sink ready.
- `m_data`  out  DW  stream data (signed).

## Operation
- States:
  - IDLE: `start` with `len`>0 goes to RUN; `start` with `len`=0 goes to DONE.
  - RUN: issues reads. After the last read is issued, goes to DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty, then goes to DONE.
  - DONE: pulses `done`, returns to IDLE.
- `start` outside IDLE is ignored. The sampled `base_addr` and `len` are held internally, so later changes on those inputs have no effect.
- Issue rule, RUN only: `mem_en`=1 iff `count + inflight - pop < 2`.
  - `count` is the buffer occupancy (0..2).
  - `inflight` is the read issued last cycle (0/1).
  - `pop` is `m_valid & m_ready`.
- Address:
  - Starts at `base_addr`; increments by 1 per issued read.
  - Wraps modulo DEPTH: the address after DEPTH-1 is 0, including when DEPTH is not a power of two.
  - `mem_addr` is held when `mem_en`=0.
- Return path:
  - `mem_dout` is captured into the buffer the cycle after each issue. The buffer can never overflow under the issue rule.
  - `m_data` is the buffer head; order is preserved exactly.
- Stream rules:
  - Once `m_valid` rises, `m_valid` and `m_data` stay stable until `pop`.
  - `m_valid` does not depend combinationally on `m_ready`.
- Exactly `len` beats are emitted per transfer.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `m_valid`=0, `m_data`=0. State is IDLE; buffer and counters are cleared.
- `start` accepted at edge N:
  - `busy`=1 and `mem_en`=1 with `mem_addr`=`base_addr` in cycle N+1.
  - Data is captured at the end of N+2.
  - First `m_valid`=1 is in cycle N+3.
- Throughput: with `m_ready` held high, one beat per cycle.
  - Last beat at cycle N+2+`len`.
  - `done`=1 at N+3+`len`; `busy` falls the following cycle.
- `len`=0: `done` pulses at N+1; no `mem_en`, no beats.
- Backpressure: with `m_ready` low, at most 2 words are buffered, and `mem_en` stays low while `count + inflight` = 2. Issue resumes in the same cycle as a `pop`.
- `rst_n` asserted mid-transfer: all outputs return to reset values immediately (asynchronous). The in-flight RAM word is discarded and the transfer is abandoned with no `done`.

## Configuration
- `BRAM_RD_STRIDE_EN`: when defined, adds input port `stride` [AW-1:0], sampled with `start`. The address advances by `stride` modulo DEPTH per read; `stride`=0 re-reads `base_addr`.
- Without the macro: no `stride` port; the increment is fixed at 1.

## Test plan
- Full-rate read: RAM preloaded with `mem[i]=i`, `base_addr`=10, `len`=4, `m_ready`=1 -> beats 10,11,12,13 on consecutive cycles starting N+3; `done` at N+7.
- Backpressure: `len`=6, `m_ready` toggling 1,0,0,1,... -> all 6 beats in order; `m_data` stable while stalled; `mem_en` never high when buffered + in-flight = 2.
- Wrap: DEPTH=1000, `base_addr`=998, `len`=4 -> addresses 998, 999, 0, 1 issued in that order.
- Zero length and ignored start: `len`=0 -> `done` at N+1, no `mem_en`. A second `start` while `busy` -> no effect on the running transfer.
- Async reset mid-transfer: assert `rst_n`=0 after 2 beats -> all outputs 0 at once. A following `start` with `len`=3 -> a clean 3-beat transfer.
- With `BRAM_RD_STRIDE_EN` defined: `base_addr`=0, `stride`=28, `len`=3 -> reads addresses 0, 28, 56.
